// File: rtl/bfn_train_sequencer.sv
// Training sequencer for the bias-free perceptron predictor: filters resolved
// branch records, queues those needing training, and read-modify-writes each row.
module bfn_train_sequencer #(
  parameter int IDX_W = 6,
  parameter int NUM_W = 16,
  parameter int WBITS = 3,
  parameter int SUM_W = 8,
  parameter int THETA = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [IDX_W-1:0]         upd_index,
  input  logic                     upd_taken,
  input  logic                     upd_pred,
  input  logic [SUM_W-1:0]         upd_sum_mag,
  input  logic [NUM_W-2:0]         upd_hist,
  input  logic                     pred_rd_en,
  input  logic [IDX_W-1:0]         pred_rd_index,
  output logic                     tbl_en,
  output logic                     tbl_we,
  output logic [IDX_W-1:0]         tbl_addr,
  output logic [NUM_W*WBITS-1:0]   tbl_wdata,
  input  logic [NUM_W*WBITS-1:0]   tbl_rdata,
  output logic                     busy,
  output logic [15:0]              train_cnt,
  output logic [15:0]              skip_cnt
);

  localparam int ROW_W = NUM_W * WBITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]       FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [SUM_W-1:0]     THETA_V  = SUM_W'(THETA);
  localparam logic [WBITS-1:0]     W_MAX    = {1'b0, {(WBITS-1){1'b1}}};
  localparam logic [WBITS-1:0]     W_MIN    = {1'b1, {(WBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MOD  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // One saturating step of a weight toward +max (up) or -min (down).
  function automatic logic [WBITS-1:0] sat_step(input logic [WBITS-1:0] w, input logic up);
    logic [WBITS-1:0] r;
    if (up) begin
      if (w == W_MAX) r = w;
      else            r = w + WBITS'(1);
    end else begin
      if (w == W_MIN) r = w;
      else            r = w - WBITS'(1);
    end
    return r;
  endfunction

  // Weight k moves up exactly when the outcome sign matches its input sign.
  function automatic logic [ROW_W-1:0] train_row(input logic [ROW_W-1:0] row,
                                                 input logic taken,
                                                 input logic [NUM_W-2:0] hist);
    logic [NUM_W-1:0] x_pos;
    logic [ROW_W-1:0] r;
    x_pos = {hist, 1'b1};
    r = '0;
    for (int k = 0; k < NUM_W; k++) begin
      r[k*WBITS +: WBITS] = sat_step(row[k*WBITS +: WBITS], ~(taken ^ x_pos[k]));
    end
    return r;
  endfunction

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    fifo_index_r [DEPTH];
  logic                fifo_taken_r [DEPTH];
  logic [NUM_W-2:0]    fifo_hist_r  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]      cnt_r;
  logic [ROW_W-1:0]    new_row_r;
  logic [15:0]         train_cnt_r, skip_cnt_r;

  logic                full_s, empty_s, ready_s, accept_s, train_s, push_s, skip_s, pop_s;
  logic [IDX_W-1:0]    head_index_s;
  logic                head_taken_s;
  logic [NUM_W-2:0]    head_hist_s;
  logic                tbl_en_s, tbl_we_s;
  logic [IDX_W-1:0]    tbl_addr_s;
  logic [ROW_W-1:0]    tbl_wdata_s;

  assign full_s       = (cnt_r == FULL_CNT);
  assign empty_s      = (cnt_r == '0);
  assign ready_s      = rst_n & ~full_s;
  assign accept_s     = upd_valid & ready_s;
  assign train_s      = (upd_taken != upd_pred) | (upd_sum_mag <= THETA_V);
  assign push_s       = accept_s & train_s;
  assign skip_s       = accept_s & ~train_s;
  assign pop_s        = (state_r == ST_WR) & ~pred_rd_en;
  assign head_index_s = fifo_index_r[rd_ptr_r];
  assign head_taken_s = fifo_taken_r[rd_ptr_r];
  assign head_hist_s  = fifo_hist_r[rd_ptr_r];

  // Training FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_index_r[i] <= '0;
        fifo_taken_r[i] <= 1'b0;
        fifo_hist_r[i]  <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_index_r[wr_ptr_r] <= upd_index;
        fifo_taken_r[wr_ptr_r] <= upd_taken;
        fifo_hist_r[wr_ptr_r]  <= upd_hist;
        wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Trained/skipped record counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_cnt_r <= 16'd0;
      skip_cnt_r  <= 16'd0;
    end else begin
      if (push_s) train_cnt_r <= train_cnt_r + 16'd1;
      if (skip_s) skip_cnt_r  <= skip_cnt_r + 16'd1;
    end
  end

  // FSM state and the updated row computed while the port is free for lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      new_row_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_MOD) begin
        new_row_r <= train_row(tbl_rdata, head_taken_s, head_hist_s);
      end
    end
  end

  // Next-state logic; a lookup on the port stalls RD and WR only.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) state_s = ST_RD;
        else          state_s = ST_IDLE;
      end
      ST_RD: begin
        if (!pred_rd_en) state_s = ST_MOD;
        else             state_s = ST_RD;
      end
      ST_MOD: begin
        state_s = ST_WR;
      end
      ST_WR: begin
        if (!pred_rd_en) state_s = ST_IDLE;
        else             state_s = ST_WR;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Table port arbitration: lookups win; reset forces the port quiet at once.
  always_comb begin
    tbl_en_s    = 1'b0;
    tbl_we_s    = 1'b0;
    tbl_addr_s  = '0;
    tbl_wdata_s = '0;
    if (!rst_n) begin
      tbl_en_s = 1'b0;
    end else if (pred_rd_en) begin
      tbl_en_s   = 1'b1;
      tbl_addr_s = pred_rd_index;
    end else if (state_r == ST_RD) begin
      tbl_en_s   = 1'b1;
      tbl_addr_s = head_index_s;
    end else if (state_r == ST_WR) begin
      tbl_en_s    = 1'b1;
      tbl_we_s    = 1'b1;
      tbl_addr_s  = head_index_s;
      tbl_wdata_s = new_row_r;
    end else begin
      tbl_en_s = 1'b0;
    end
  end

  assign upd_ready = ready_s;
  assign tbl_en    = tbl_en_s;
  assign tbl_we    = tbl_we_s;
  assign tbl_addr  = tbl_addr_s;
  assign tbl_wdata = tbl_wdata_s;
  assign busy      = ~empty_s | (state_r != ST_IDLE);
  assign train_cnt = train_cnt_r;
  assign skip_cnt  = skip_cnt_r;

endmodule

// File: tb/tb_bfn_train_sequencer.sv
// Scoreboard bench for bfn_train_sequencer: a model table plus a record queue
// predict every table write; a forked monitor checks the port each cycle.
module tb_bfn_train_sequencer;
  localparam int IDX_W = 6, NUM_W = 16, WBITS = 3, SUM_W = 8, THETA = 12, DEPTH = 4;
  localparam int RW = NUM_W * WBITS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic upd_valid = 1'b0, upd_ready, upd_taken = 1'b0, upd_pred = 1'b0;
  logic [IDX_W-1:0] upd_index = '0, pred_rd_index = '0, tbl_addr;
  logic [SUM_W-1:0] upd_sum_mag = '0;
  logic [NUM_W-2:0] upd_hist = '0;
  logic pred_rd_en = 1'b0, tbl_en, tbl_we, busy;
  logic [RW-1:0] tbl_wdata, tbl_rdata;
  logic [15:0] train_cnt, skip_cnt;

  bfn_train_sequencer dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .upd_sum_mag(upd_sum_mag), .upd_hist(upd_hist), .pred_rd_en(pred_rd_en),
    .pred_rd_index(pred_rd_index), .tbl_en(tbl_en), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .busy(busy), .train_cnt(train_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit taken; logic [NUM_W-2:0] hist; } rec_t;
  rec_t exp_q[$];
  logic [RW-1:0] mem [64];
  logic [RW-1:0] ref_tbl [64];
  logic load_en = 1'b0;
  logic [IDX_W-1:0] load_idx = '0;
  logic [RW-1:0] load_val = '0;
  int tests = 0, fails = 0, cyc = 0, n_train = 0, n_skip = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, lk_mode = 0;
  int wr_stamps[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Weight RAM: one port, read data one cycle after the read.
  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wt(input logic [RW-1:0] row, input int k);
    return $signed(row[k*WBITS +: WBITS]);
  endfunction

  function automatic logic [RW-1:0] with_wt(input logic [RW-1:0] row, input int k, input int v);
    logic [RW-1:0] r;
    r = row;
    r[k*WBITS +: WBITS] = v[WBITS-1:0];
    return r;
  endfunction

  // Reference rule: w_k += t*x_k, clamped to the representable range.
  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] row, input rec_t r);
    logic [RW-1:0] o;
    int t, x, nw;
    o = '0;
    t = r.taken ? 1 : -1;
    for (int k = 0; k < NUM_W; k++) begin
      x = 1;
      if (k > 0) x = r.hist[k-1] ? 1 : -1;
      nw = wt(row, k) + t * x;
      if (nw > 3) nw = 3;
      if (nw < -4) nw = -4;
      o = with_wt(o, k, nw);
    end
    return o;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [63:0] tmp;
    tmp = {$urandom, $urandom};
    return tmp[RW-1:0];
  endfunction

  task automatic monitor();
    rec_t r;
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tbl_en) begin
        if (pred_rd_en) begin
          chk("lookup_port", {tbl_we, tbl_addr}, {1'b0, pred_rd_index});
        end else begin
          chk("fsm_access_pending", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            if (!tbl_we) begin
              last_rd_cyc = cyc;
              chk("rd_addr", tbl_addr, exp_q[0].idx);
            end else begin
              r = exp_q.pop_front();
              e = model_row(ref_tbl[r.idx], r);
              ref_tbl[r.idx] = e;
              last_wr_cyc = cyc;
              wr_stamps.push_back(cyc);
              chk("wr_addr", tbl_addr, r.idx);
              chk("wr_data", tbl_wdata, e);
            end
          end
        end
      end
    end
  endtask

  task automatic lookup_drv();
    forever begin
      @(posedge clk); #2;
      case (lk_mode)
        0:       pred_rd_en = 1'b0;
        1:       pred_rd_en = 1'b1;
        default: pred_rd_en = ($urandom_range(0, 9) < 3);
      endcase
      pred_rd_index = IDX_W'($urandom_range(0, 63));
    end
  endtask

  task automatic load_row(input int i, input logic [RW-1:0] v);
    @(posedge clk); #1;
    load_en = 1'b1; load_idx = IDX_W'(i); load_val = v; ref_tbl[i] = v;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Presents one record for one cycle; acc reports whether it was taken.
  task automatic send(input int idx, input bit tk, input bit pd, input int sm,
                      input logic [NUM_W-2:0] hs, output bit acc);
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_index = IDX_W'(idx); upd_taken = tk; upd_pred = pd;
    upd_sum_mag = SUM_W'(sm); upd_hist = hs;
    @(negedge clk);
    acc = upd_ready;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    if (acc) begin
      if (tk != pd || sm <= THETA) begin
        exp_q.push_back('{idx, tk, hs});
        n_train++;
      end else n_skip++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, {busy, 32'(exp_q.size())}, 64'd0);
  endtask

  task automatic chk_cnt(input string name);
    chk(name, {train_cnt, skip_cnt}, {16'(n_train), 16'(n_skip)});
  endtask

  initial begin
    bit acc;
    int rel_cyc, tries;
    logic [RW-1:0] row;
    fork
      monitor();
      lookup_drv();
    join_none

    #12;
    chk("reset_outputs", {tbl_en, tbl_we, tbl_addr, tbl_wdata, upd_ready, busy}, 64'd0);
    chk("reset_counters", {train_cnt, skip_cnt}, 64'd0);
    for (int i = 0; i < 64; i++) load_row(i, rand_row());
    @(negedge clk); rst_n = 1'b1;

    // Single mispredicted record on a zero row.
    load_row(5, '0);
    send(5, 1'b1, 1'b0, 100, '1, acc);
    drain("drain_first");
    chk("rd_to_wr_gap", last_wr_cyc - last_rd_cyc, 2);
    row = {NUM_W{3'b001}};
    chk("row5_all_plus1", mem[5], row);
    chk_cnt("cnt_first");

    // Confident correct prediction is skipped; sum equal to THETA trains.
    send(7, 1'b1, 1'b1, 40, 15'($urandom), acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("skip_busy_low", busy, 0);
    end
    chk_cnt("cnt_skip");
    send(7, 1'b0, 1'b0, 12, 15'($urandom), acc);
    drain("drain_theta");
    chk_cnt("cnt_theta");

    // Saturation at both ends.
    row = with_wt(with_wt('0, 0, 3), 1, -4);
    load_row(9, row);
    send(9, 1'b1, 1'b0, 100, 15'($urandom) & 15'h7FFE, acc);
    drain("drain_sat1");
    chk("sat_w0_hi", 64'(wt(mem[9], 0)), 64'(3));
    chk("sat_w1_lo", 64'(wt(mem[9], 1)), 64'(-4));
    send(9, 1'b0, 1'b1, 100, 15'($urandom) & 15'h7FFE, acc);
    drain("drain_sat2");
    chk("dec_w0", 64'(wt(mem[9], 0)), 64'(2));
    chk("inc_w1", 64'(wt(mem[9], 1)), 64'(-3));

    // Lookup contention during RD, then during WR.
    send(11, 1'b1, 1'b0, 100, 15'($urandom), acc);
    @(posedge clk); #1; lk_mode = 1;
    repeat (5) @(posedge clk);
    #1; lk_mode = 0; rel_cyc = cyc;
    drain("drain_rd_stall");
    chk("rd_stall_wr_after", 64'(last_wr_cyc >= rel_cyc), 64'd1);
    chk("rd_stall_gap", last_wr_cyc - last_rd_cyc, 2);
    send(12, 1'b0, 1'b1, 100, 15'($urandom), acc);
    repeat (3) @(posedge clk);
    #1; lk_mode = 1;
    repeat (5) @(posedge clk);
    #1; lk_mode = 0; rel_cyc = cyc;
    drain("drain_wr_stall");
    chk("wr_stall_wr_after", 64'(last_wr_cyc >= rel_cyc), 64'd1);

    // Fill the FIFO under continuous lookups.
    load_row(20, '0);
    lk_mode = 1;
    send(20, 1'b1, 1'b0, 100, '1, acc); chk("fill_acc0", acc, 1);
    send(21, 1'b0, 1'b1, 100, 15'($urandom), acc); chk("fill_acc1", acc, 1);
    send(20, 1'b1, 1'b0, 100, '1, acc); chk("fill_acc2", acc, 1);
    send(22, 1'b1, 1'b0, 5, 15'($urandom), acc); chk("fill_acc3", acc, 1);
    send(23, 1'b1, 1'b0, 100, 15'($urandom), acc); chk("fill_ready_low", acc, 0);
    wr_stamps.delete();
    lk_mode = 0;
    drain("drain_fill");
    chk("fill_writes", wr_stamps.size(), 4);
    for (int i = 1; i < 4 && i < wr_stamps.size(); i++)
      chk("wr_spacing", wr_stamps[i] - wr_stamps[i-1], 4);
    row = {NUM_W{3'b010}};
    chk("same_index_accum", mem[20], row);
    chk_cnt("cnt_fill");

    // Asynchronous reset while the write is on the port.
    send(30, 1'b1, 1'b0, 100, 15'($urandom), acc);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_state_reached", {tbl_en, tbl_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    exp_q.delete(); n_train = 0; n_skip = 0;
    chk("rst_outputs", {tbl_en, tbl_we, tbl_addr, tbl_wdata, upd_ready, busy}, 64'd0);
    chk_cnt("rst_counters");
    repeat (2) @(posedge clk);
    #1;
    chk("no_partial_write", mem[30], ref_tbl[30]);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_busy", busy, 0);

    // Randomized records with random lookup traffic.
    lk_mode = 2;
    for (int n = 0; n < 80; n++) begin
      int idx, sm;
      bit tk, pd;
      logic [NUM_W-2:0] hs;
      idx = $urandom_range(0, 7); tk = 1'($urandom); pd = 1'($urandom);
      sm = $urandom_range(0, 30); hs = 15'($urandom);
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 200) begin
        send(idx, tk, pd, sm, hs, acc);
        tries++;
      end
      if (!acc) chk("rand_accept_timeout", tries, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    #1; lk_mode = 0;
    drain("drain_random");
    chk_cnt("cnt_random");
    tries = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_tbl[i]) tries++;
    chk("table_matches_model", tries, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bfn_train_sequencer.md
Name: bfn_train_sequencer

Overview:
- Training controller for the bias-free neural predictor weight table.
- Accepts resolved-branch records from EX and decides whether each perceptron row needs training. Queues records that need training.
- Performs a read-modify-write of each queued row on the single shared table port. Predictor lookups always take priority on that port.
- Sits between EX-stage resolution and the perceptron weight RAM, in parallel with the lookup path.

Parameters:
- IDX_W, 6, table index width (64 rows).
- NUM_W, 16, weights per row; w[0] is the bias weight (input fixed at +1), w[1..NUM_W-1] are history weights.
- WBITS, 3, weight width: two's complement, saturating range -4..+3.
- SUM_W, 8, width of the perceptron-sum magnitude supplied by the lookup path.
- THETA, 12, training threshold on the sum magnitude.
- DEPTH, 4, depth of the training FIFO (power of 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- upd_valid  in  1  resolved branch record valid.
- upd_ready  out  1  record can be accepted this cycle.
- upd_index  in  IDX_W  row index used at prediction time.
- upd_taken  in  1  actual branch direction.
- upd_pred  in  1  predicted direction.
- upd_sum_mag  in  SUM_W  magnitude of the perceptron sum at prediction time.
- upd_hist  in  NUM_W-1  history bits used at prediction; 1 = +1, 0 = -1.
- pred_rd_en  in  1  predictor lookup request (highest priority).
- pred_rd_index  in  IDX_W  lookup row.
- tbl_en  out  1  table access enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  IDX_W  table address.
- tbl_wdata  out  NUM_W*WBITS  write row; weight k occupies bits [k*WBITS +: WBITS].
- tbl_rdata  in  NUM_W*WBITS  read row, valid one cycle after a read.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- train_cnt  out  16  trained-record counter; wraps at 0xFFFF -> 0.
- skip_cnt  out  16  discarded-record counter; wraps the same way.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. Reset mid-operation abandons any read or write in progress; no partial write is issued.
- Accept: a record is accepted when upd_valid & upd_ready. upd_ready = FIFO not full.
- Train decision at accept: train = (upd_taken != upd_pred) | (upd_sum_mag <= THETA).
  - train=0: record dropped, skip_cnt +1.
  - train=1: record pushed to FIFO, train_cnt +1.
- Simultaneous push and pop on a full FIFO is not allowed: ready stays low while full.
- Port arbitration (combinational, every cycle):
  - pred_rd_en=1: tbl_en=1, tbl_we=0, tbl_addr=pred_rd_index. The FSM holds its state.
  - Otherwise the FSM drives the port.
- FSM states:
  - IDLE: FIFO non-empty -> RD.
  - RD: if the port is free, issue tbl_en=1, tbl_we=0, tbl_addr=head.index, then -> MOD. If lookup wins, stay in RD.
  - MOD: capture tbl_rdata. Compute the new row into a register, then -> WR. The port is not needed in this state, so a lookup here causes no stall.
  - WR: if the port is free, issue tbl_en=1, tbl_we=1, tbl_addr=head.index, tbl_wdata=new row; pop the FIFO; -> IDLE. If lookup wins, stay in WR, holding the row.
- Minimum latency is 3 cycles per record: RD -> MOD -> WR. IDLE -> RD takes one extra cycle.
- Weight update: t = +1 if taken, -1 if not. x0 = +1; xk = upd_hist[k-1] ? +1 : -1. New wk = sat(wk + t*xk).
  - Saturation: +3 plus 1 stays +3; -4 minus 1 stays -4.
  - The arithmetic is never allowed to wrap.
- Ordering: records are processed strictly in FIFO order. The RD of the next record cannot precede the previous WR, so back-to-back updates to the same index see the prior write.
- Lookup reading a row with a pending write gets the old data. This is accepted, and no forwarding is done.
- busy deasserts the cycle after the final WR, once the FIFO is empty.

Test Plan:
- Reset, then one mispredicted record: index 5, taken=1, pred=0, hist all 1s; row 5 has all weights 0. Required: RD at addr 5, then WR 2 cycles later with every weight = +1; train_cnt=1.
- Correct prediction with upd_sum_mag=40 (> THETA). Required: no table access, skip_cnt=1, busy stays 0. Then sum_mag=12 (equal to THETA). Required: record trains.
- Saturation: row with w0=+3, w1=-4; taken=1, hist[0]=0. Required: w0 stays +3 and w1 becomes -4+(-1)... saturates at -4. Repeat with taken=0: w0 becomes +2, w1 becomes -3.
- Lookup contention: hold pred_rd_en=1 for 5 cycles while the FSM is in RD, and again in WR. Required: the port shows only lookup reads; the FSM resumes and the write lands intact after pred_rd_en drops.
- Fill the FIFO with 4 training records under continuous lookups. Required: upd_ready=0 on the 5th record. Release lookups; required: 4 writes in order at 4-cycle spacing, and two updates to the same index accumulate (+2).
- Assert rst_n low while in WR. Required: no write issued, all counters 0, FIFO empty, outputs 0 immediately (asynchronous).
